// File: rtl/byte_word_bus_packer_pkg.sv
// Shared types and constants for the byte-to-word bus packer.
package byte_word_bus_packer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StDrive   = 2'd2,
        StRelease = 2'd3
    } bus_state_e;

    // Place the first byte of a pair in the low half when lsb_first is set.
    function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] first_b,
                                                    input logic [BYTE_W-1:0] second_b,
                                                    input bit lsb_first);
        return lsb_first ? {second_b, first_b} : {first_b, second_b};
    endfunction

endpackage

// File: rtl/byte_word_bus_packer_if.sv
// Upstream byte handshake, bus arbitration and status signals of the packer.
interface byte_word_bus_packer_if #(
    parameter int unsigned DEPTH = 4
);
    import byte_word_bus_packer_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              flush;
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_strobe;
    logic [CW-1:0]     fill_level;
    logic [15:0]       words_sent;

    modport master (
        input  byte_in, byte_valid, flush, bus_gnt,
        output byte_ready, bus_req, bus_strobe, fill_level, words_sent
    );

    modport slave (
        output byte_in, byte_valid, flush, bus_gnt,
        input  byte_ready, bus_req, bus_strobe, fill_level, words_sent
    );

endinterface

// File: rtl/word_fifo.sv
// Synchronous power-of-two word FIFO; head is the oldest entry, read without a pop.
module word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array, no reset needed since entries are only read when counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/byte_word_bus_packer.sv
// Packs byte pairs into words, queues them and writes them onto a shared tristate bus.
module byte_word_bus_packer
    import byte_word_bus_packer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    byte_word_bus_packer_if.master io,
    inout  wire  [WORD_W-1:0]    bus_data
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              half_valid_q, half_valid_d;
    logic [BYTE_W-1:0] half_q, half_d;
    logic              byte_ready, accept, push_pair, push_flush, push, pop;
    logic [WORD_W-1:0] push_data, fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    bus_state_e        state_q, state_d;
    logic              req_q, strobe_q;
    logic [15:0]       sent_q;

    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Packer: ready depends only on registered state; flush yields to a completing byte.
    always_comb begin
        byte_ready   = !half_valid_q || !fifo_full;
        accept       = io.byte_valid && byte_ready;
        push_pair    = accept && half_valid_q;
        push_flush   = io.flush && half_valid_q && !fifo_full && !accept;
        push         = push_pair || push_flush;
        // A flushed odd byte always sits in the low half with padding above it.
        push_data    = push_pair ? pack_word(half_q, io.byte_in, LSB_FIRST)
                                 : {PAD_BYTE, half_q};
        half_d       = half_q;
        half_valid_d = half_valid_q;
        if (accept && !half_valid_q) begin
            half_d       = io.byte_in;
            half_valid_d = 1'b1;
        end else if (push) begin
            half_valid_d = 1'b0;
        end
    end

    // Bus FSM next state; the head word is popped on the DRIVE exit edge.
    always_comb begin
        state_d = state_q;
        pop     = (state_q == StDrive);
        unique case (state_q)
            StIdle:    if (!fifo_empty) state_d = StReq;
            StReq:     if (io.bus_gnt) state_d = StDrive;
            StDrive:   state_d = StRelease;
            StRelease: state_d = fifo_empty ? StIdle : StReq;
            default:   state_d = StIdle;
        endcase
    end

    // State plus registered request/strobe, so bus_gnt never reaches bus_data combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            strobe_q     <= 1'b0;
            half_valid_q <= 1'b0;
            half_q       <= '0;
            sent_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= (state_d == StReq) || (state_d == StDrive);
            strobe_q     <= (state_d == StDrive);
            half_valid_q <= half_valid_d;
            half_q       <= half_d;
            if (pop) sent_q <= sent_q + 16'd1;
        end
    end

    assign bus_data      = strobe_q ? fifo_head : {WORD_W{1'bz}};
    assign io.byte_ready = byte_ready;
    assign io.bus_req    = req_q;
    assign io.bus_strobe = strobe_q;
    assign io.fill_level = fifo_count;
    assign io.words_sent = sent_q;

endmodule

// File: tb/tb_byte_word_bus_packer.sv
// Two packers (LSB_FIRST=1 and 0) share one stimulus; a queue model predicts the bus words.
module tb_byte_word_bus_packer;
    import byte_word_bus_packer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    tri1 [15:0] bus0;
    tri1 [15:0] bus1;

    byte_word_bus_packer_if #(.DEPTH(DEPTH)) i0 ();
    byte_word_bus_packer_if #(.DEPTH(DEPTH)) i1 ();

    byte_word_bus_packer #(.DEPTH(DEPTH), .LSB_FIRST(1'b1)) u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .io       (i0.master),
        .bus_data (bus0)
    );

    byte_word_bus_packer #(.DEPTH(DEPTH), .LSB_FIRST(1'b0)) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .io       (i1.master),
        .bus_data (bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last0 = -100;
    int last1 = -100;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] sent0 = 16'd0;
    logic [15:0] sent1 = 16'd0;
    logic        pend = 1'b0;
    logic [7:0]  pb = 8'h00;
    bit          pop0 = 1'b0;
    bit          pop1 = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=strobe required=no_word_queued t=%0t", name, $time);
    endtask

    // Monitor: one look per cycle before the edge; pops the expected word on each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("fill0", 32'(i0.fill_level), 32'(q0.size()));
                chk("fill1", 32'(i1.fill_level), 32'(q1.size()));
                chk("ready0", 32'(i0.byte_ready), 32'(!(pend && q0.size() == DEPTH)));
                chk("ready1", 32'(i1.byte_ready), 32'(!(pend && q1.size() == DEPTH)));
                chk("sent0", 32'(i0.words_sent), 32'(sent0));
                chk("sent1", 32'(i1.words_sent), 32'(sent1));
                pop0 = 1'b0;
                pop1 = 1'b0;
                if (i0.bus_strobe) begin
                    chk("gap0", 32'(cyc - last0 >= 3), 32'(1));
                    last0 = cyc;
                    if (q0.size() == 0) unexpected("data0");
                    else begin
                        chk("data0", 32'(bus0), 32'(q0.pop_front()));
                        sent0++;
                        pop0 = 1'b1;
                    end
                end else chk("release0", 32'(bus0), 32'hFFFF);
                if (i1.bus_strobe) begin
                    chk("gap1", 32'(cyc - last1 >= 3), 32'(1));
                    last1 = cyc;
                    if (q1.size() == 0) unexpected("data1");
                    else begin
                        chk("data1", 32'(bus1), 32'(q1.pop_front()));
                        sent1++;
                        pop1 = 1'b1;
                    end
                end else chk("release1", 32'(bus1), 32'hFFFF);
            end
            cyc++;
        end
    end

    task automatic drive(input bit v, input logic [7:0] b, input bit f, input bit g);
        i0.byte_valid = v; i0.byte_in = b; i0.flush = f; i0.bus_gnt = g;
        i1.byte_valid = v; i1.byte_in = b; i1.flush = f; i1.bus_gnt = g;
    endtask

    // One clock: drive after the edge, then predict what the next edge does to the stream.
    task automatic cycle(input bit v, input logic [7:0] b, input bit f, input bit g,
                         output bit acc);
        int fill_pre;
        @(posedge clk);
        #1;
        drive(v, b, f, g);
        @(negedge clk);
        #1;
        fill_pre = q0.size() + (pop0 ? 1 : 0);
        acc = v && i0.byte_ready;
        if (acc) begin
            if (!pend) begin
                pend = 1'b1;
                pb   = b;
            end else begin
                q0.push_back({b, pb});
                q1.push_back({pb, b});
                pend = 1'b0;
            end
        end else if (f && pend && fill_pre < DEPTH) begin
            q0.push_back({8'h00, pb});
            q1.push_back({8'h00, pb});
            pend = 1'b0;
        end
    endtask

    task automatic idle(input int n, input bit g);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, g, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit g);
        bit acc = 1'b0;
        for (int i = 0; i < 60 && !acc; i++) cycle(1'b1, b, 1'b0, g, acc);
        if (!acc) $display("FAIL send_byte actual=not_accepted required=accepted b=%0h", b);
        if (!acc) begin checks++; failures++; end
    endtask

    task automatic wait_strobe(input bit g);
        bit acc;
        for (int i = 0; i < 20 && !i0.bus_strobe; i++) cycle(1'b0, 8'h00, 1'b0, g, acc);
        chk("wait_strobe", 32'(i0.bus_strobe), 32'(1));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_bus0"}, 32'(bus0), 32'hFFFF);
        chk({tag, "_bus1"}, 32'(bus1), 32'hFFFF);
        chk({tag, "_strobe"}, 32'(i0.bus_strobe | i1.bus_strobe), 32'(0));
        chk({tag, "_req"}, 32'(i0.bus_req | i1.bus_req), 32'(0));
        chk({tag, "_fill"}, 32'(i0.fill_level), 32'(0));
        chk({tag, "_sent"}, 32'(i0.words_sent), 32'(0));
        chk({tag, "_ready"}, 32'(i0.byte_ready & i1.byte_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int ws_prev;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 mon_en = 1'b1;

        // Single pair with grant tied high: exact request/strobe/release timing.
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(1, 1'b1);
        chk("t_req_after_push", 32'(i0.bus_req), 32'(0));
        idle(1, 1'b1);
        chk("t_req", 32'(i0.bus_req), 32'(1));
        chk("t_strobe_pre", 32'(i0.bus_strobe), 32'(0));
        idle(1, 1'b1);
        chk("t_strobe", 32'(i0.bus_strobe), 32'(1));
        chk("t_word", 32'(bus0), 32'h1234);
        idle(1, 1'b1);
        chk("t_release_strobe", 32'(i0.bus_strobe), 32'(0));
        chk("t_release_req", 32'(i0.bus_req), 32'(0));
        chk("t_sent", 32'(i0.words_sent), 32'(1));

        // Byte order, then an odd byte padded by flush.
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        idle(4, 1'b1);
        send_byte(8'h55, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        idle(6, 1'b1);

        // Grant withheld: FIFO fills, tenth byte stalls, then everything drains in order.
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h19, 1'b0, 1'b0, acc);
        chk("full_fill", 32'(i0.fill_level), 32'(DEPTH));
        chk("full_ready", 32'(i0.byte_ready), 32'(0));
        send_byte(8'h19, 1'b1);
        idle(20, 1'b1);

        // Grant dropped during DRIVE: word completes exactly once.
        ws_prev = int'(sent0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_strobe(1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("drop_strobe", 32'(i0.bus_strobe), 32'(0));
        chk("drop_req", 32'(i0.bus_req), 32'(0));
        chk("drop_sent", 32'(i0.words_sent), 32'(ws_prev + 1));
        idle(3, 1'b0);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, acc);
        idle(30, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        idle(12, 1'b1);
        chk("drained", 32'(q0.size() + q1.size()), 32'(0));

        // words_sent wrap from 16'hFFFF.
        @(posedge clk);
        #1;
        force u0.sent_q = 16'hFFFF;
        force u1.sent_q = 16'hFFFF;
        #1;
        release u0.sent_q;
        release u1.sent_q;
        sent0 = 16'hFFFF;
        sent1 = 16'hFFFF;
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        idle(6, 1'b1);
        chk("wrap", 32'(i0.words_sent), 32'(0));

        // Reset in the middle of DRIVE discards everything and frees the bus at once.
        for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), 1'b0);
        wait_strobe(1'b1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        q0.delete();
        q1.delete();
        pend = 1'b0;
        sent0 = 16'd0;
        sent1 = 16'd0;
        pop0 = 1'b0;
        pop1 = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(8, 1'b1);
        chk("post_reset_sent", 32'(i0.words_sent), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
